// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared constants, FSM state type and digit-limit helper for
//               the stopwatch input front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam logic [2:0] SEL_SEC_R = 3'd0;
    localparam logic [2:0] SEL_SEC_L = 3'd1;
    localparam logic [2:0] SEL_MIN_R = 3'd2;
    localparam logic [2:0] SEL_MIN_L = 3'd3;
    localparam logic [2:0] SEL_NONE  = 3'd5;

    localparam logic [3:0] MAX_SEC_L = 4'd5;
    localparam logic [3:0] MAX_DIGIT = 4'd9;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        ADJUST = 1'b1
    } fsm_state_e;

    // Only the tens-of-seconds digit stops at 5; every other digit runs to 9.
    function automatic logic [3:0] digit_max(input logic [2:0] sel);
        logic [3:0] max_val;
        case (sel)
            SEL_SEC_L:                       max_val = MAX_SEC_L;
            SEL_SEC_R, SEL_MIN_R, SEL_MIN_L: max_val = MAX_DIGIT;
            default:                         max_val = MAX_DIGIT;
        endcase
        return max_val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchroniser, stability counter and rising-edge
//               press pulse for one raw board input.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;

    // The counter only runs while the synchronised sample disagrees with the
    // accepted level, so any bounce back restarts the stability window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_press <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/adj_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adj_input_ctrl
// Description : Stopwatch front-end: debounced pause/reset control and
//               digit-by-digit adjust mode with one-cycle write strobes.
//               Define ADJ_AUTOREPEAT_EN to enable increment auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module adj_input_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_CYCLES   = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_pause_raw,
    input  logic       btn_reset_raw,
    input  logic       btn_sel_raw,
    input  logic       btn_inc_raw,
    input  logic       sw_adj,
    output logic       paused,
    output logic       rst_cnt,
    output logic       adj,
    output logic [2:0] adj_sel,
    output logic [3:0] adj_val,
    output logic       btn_set_pause
);

`ifdef ADJ_AUTOREPEAT_EN
    localparam logic c_AUTOREPEAT = 1'b1;
`else
    localparam logic c_AUTOREPEAT = 1'b0;
`endif

    localparam int                c_REP_W    = $clog2(REPEAT_CYCLES + 1);
    localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT_CYCLES - 1);

    logic [4:0] w_raw;
    logic [4:0] w_lvl;
    logic [4:0] w_press;

    assign w_raw = {sw_adj, btn_inc_raw, btn_sel_raw, btn_reset_raw, btn_pause_raw};

    for (genvar gi = 0; gi < 5; gi++) begin : g_debounce
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (w_raw[gi]),
            .level(w_lvl[gi]),
            .press(w_press[gi])
        );
    end

    logic w_pause_press;
    logic w_reset_press;
    logic w_sel_press;
    logic w_inc_press;
    logic w_inc_lvl;
    logic w_sw_lvl;
    logic w_unused;

    assign w_pause_press = w_press[0];
    assign w_reset_press = w_press[1];
    assign w_sel_press   = w_press[2];
    assign w_inc_press   = w_press[3];
    assign w_inc_lvl     = w_lvl[3];
    assign w_sw_lvl      = w_lvl[4];
    assign w_unused      = ^{w_lvl[2:0], w_press[4]};

    fsm_state_e   r_state;
    logic         r_paused_q;
    logic         r_rst_cnt;
    logic [2:0]   r_ptr;
    logic [3:0]   r_adj_val;
    logic         r_strobe;
    logic         r_rep_armed;
    logic [c_REP_W-1:0] r_rep_cnt;

    logic w_in_adjust;
    logic w_stay_adjust;
    logic w_rep_hold;
    logic w_repeat;
    logic w_inc_evt;

    assign w_in_adjust   = (r_state == ADJUST);
    assign w_stay_adjust = w_in_adjust && w_sw_lvl;

    // Auto-repeat arms on a real increment press and disarms on release,
    // select, reset or leaving adjust mode.
    assign w_rep_hold = c_AUTOREPEAT && r_rep_armed && w_stay_adjust && w_inc_lvl &&
                        !w_sel_press && !w_reset_press && !w_inc_press;
    assign w_repeat   = w_rep_hold && (r_rep_cnt == c_REP_LAST);
    assign w_inc_evt  = w_inc_press || w_repeat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_armed <= 1'b0;
            r_rep_cnt   <= '0;
        end else begin
            r_rep_armed <= c_AUTOREPEAT && w_stay_adjust && !w_sel_press && !w_reset_press &&
                           (w_inc_press || w_rep_hold);
            if (!w_rep_hold || w_repeat) begin
                r_rep_cnt <= '0;
            end else begin
                r_rep_cnt <= r_rep_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_paused_q <= 1'b0;
            r_rst_cnt  <= 1'b0;
            r_ptr      <= SEL_SEC_R;
            r_adj_val  <= 4'd0;
            r_strobe   <= 1'b0;
        end else begin
            r_rst_cnt <= w_reset_press;
            r_strobe  <= 1'b0;
            case (r_state)
                RUN: begin
                    if (w_sw_lvl) begin
                        r_state   <= ADJUST;
                        r_ptr     <= SEL_SEC_R;
                        r_adj_val <= 4'd0;
                    end else if (w_pause_press) begin
                        r_paused_q <= ~r_paused_q;
                    end
                end
                ADJUST: begin
                    // Priority: leaving adjust, then reset, then select, then increment.
                    if (!w_sw_lvl) begin
                        r_state <= RUN;
                    end else if (w_reset_press) begin
                        r_adj_val <= 4'd0;
                    end else if (w_sel_press) begin
                        r_ptr     <= (r_ptr == SEL_MIN_L) ? SEL_SEC_R : r_ptr + 3'd1;
                        r_adj_val <= 4'd0;
                    end else if (w_inc_evt) begin
                        r_adj_val <= (r_adj_val >= digit_max(r_ptr)) ? 4'd0 : r_adj_val + 4'd1;
                        r_strobe  <= 1'b1;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign paused        = w_in_adjust ? 1'b1 : r_paused_q;
    assign rst_cnt       = r_rst_cnt;
    assign adj           = w_in_adjust;
    assign adj_sel       = w_in_adjust ? r_ptr : SEL_NONE;
    assign adj_val       = r_adj_val;
    assign btn_set_pause = r_strobe;

endmodule
`default_nettype wire

// File: tb/tb_adj_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adj_input_ctrl
// Description : Self-checking bench for adj_input_ctrl (short debounce).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adj_input_ctrl;

    localparam int OP_PAUSE  = 0;
    localparam int OP_RESET  = 1;
    localparam int OP_SEL    = 2;
    localparam int OP_INC    = 3;
    localparam int OP_SW_ON  = 4;
    localparam int OP_SW_OFF = 5;
    localparam int NV        = 22;

    typedef struct {
        int         op;
        logic [2:0] sel;
        logic [3:0] val;
        logic       paused;
        logic       adj;
        int         strobes;
        int         rsts;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [4:0] raw;
    logic       paused;
    logic       rst_cnt;
    logic       adj;
    logic [2:0] adj_sel;
    logic [3:0] adj_val;
    logic       btn_set_pause;

    int checks = 0;
    int errors = 0;
    int n_strobe = 0;
    int n_rst = 0;
    int last_sel = 0;
    int last_val = 0;
    logic prev_rst = 1'b0;

    // Reference model state
    logic m_paused_q;
    logic m_adj;
    int   m_ptr;
    int   m_val;

    vec_t vec [NV];

    adj_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .REPEAT_CYCLES  (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_pause_raw(raw[0]),
        .btn_reset_raw(raw[1]),
        .btn_sel_raw  (raw[2]),
        .btn_inc_raw  (raw[3]),
        .sw_adj       (raw[4]),
        .paused       (paused),
        .rst_cnt      (rst_cnt),
        .adj          (adj),
        .adj_sel      (adj_sel),
        .adj_val      (adj_val),
        .btn_set_pause(btn_set_pause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dmax(input int sel);
        return (sel == 1) ? 5 : 9;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int b);
        raw[b] = 1'b1;
        tick(8);
        raw[b] = 1'b0;
        tick(8);
    endtask

    task automatic do_op(input int op);
        case (op)
            OP_SW_ON:  begin raw[4] = 1'b1; tick(10); end
            OP_SW_OFF: begin raw[4] = 1'b0; tick(10); end
            default:   press(op);
        endcase
    endtask

    task automatic model_op(input int op);
        case (op)
            OP_PAUSE: if (!m_adj) m_paused_q = ~m_paused_q;
            OP_RESET: if (m_adj) m_val = 0;
            OP_SEL:   if (m_adj) begin m_ptr = (m_ptr + 1) % 4; m_val = 0; end
            OP_INC:   if (m_adj) m_val = (m_val == dmax(m_ptr)) ? 0 : m_val + 1;
            OP_SW_ON: if (!m_adj) begin m_adj = 1'b1; m_ptr = 0; m_val = 0; end
            default:  m_adj = 1'b0;
        endcase
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_paused"}, paused, 0);
        chk({tag, "_rst_cnt"}, rst_cnt, 0);
        chk({tag, "_adj"}, adj, 0);
        chk({tag, "_adj_sel"}, adj_sel, 5);
        chk({tag, "_adj_val"}, adj_val, 0);
        chk({tag, "_strobe"}, btn_set_pause, 0);
    endtask

    // Strobe/rst_cnt monitor sampled mid-cycle
    always @(negedge clk) begin
        if (btn_set_pause) begin
            n_strobe++;
            last_sel = adj_sel;
            last_val = adj_val;
            checks++;
            if (adj_sel > 3'd3 || int'(adj_val) > dmax(adj_sel)) begin
                errors++;
                $display("FAIL strobe_invariant: adj_sel=%0d adj_val=%0d", adj_sel, adj_val);
            end
        end
        if (rst_cnt) begin
            n_rst++;
            checks++;
            if (prev_rst) begin
                errors++;
                $display("FAIL rst_cnt_width: high for more than one cycle, required 1");
            end
        end
        prev_rst = rst_cnt;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int s0, r0, hi_cycles, op;

        vec[0]  = '{OP_SW_ON,  3'd0, 4'd0, 1'b1, 1'b1, 0, 0};
        vec[1]  = '{OP_INC,    3'd0, 4'd1, 1'b1, 1'b1, 1, 0};
        vec[2]  = '{OP_INC,    3'd0, 4'd2, 1'b1, 1'b1, 1, 0};
        vec[3]  = '{OP_INC,    3'd0, 4'd3, 1'b1, 1'b1, 1, 0};
        vec[4]  = '{OP_SEL,    3'd1, 4'd0, 1'b1, 1'b1, 0, 0};
        vec[5]  = '{OP_INC,    3'd1, 4'd1, 1'b1, 1'b1, 1, 0};
        vec[6]  = '{OP_INC,    3'd1, 4'd2, 1'b1, 1'b1, 1, 0};
        vec[7]  = '{OP_INC,    3'd1, 4'd3, 1'b1, 1'b1, 1, 0};
        vec[8]  = '{OP_INC,    3'd1, 4'd4, 1'b1, 1'b1, 1, 0};
        vec[9]  = '{OP_INC,    3'd1, 4'd5, 1'b1, 1'b1, 1, 0};
        vec[10] = '{OP_INC,    3'd1, 4'd0, 1'b1, 1'b1, 1, 0};
        vec[11] = '{OP_PAUSE,  3'd1, 4'd0, 1'b1, 1'b1, 0, 0};
        vec[12] = '{OP_SEL,    3'd2, 4'd0, 1'b1, 1'b1, 0, 0};
        vec[13] = '{OP_SEL,    3'd3, 4'd0, 1'b1, 1'b1, 0, 0};
        vec[14] = '{OP_SEL,    3'd0, 4'd0, 1'b1, 1'b1, 0, 0};
        vec[15] = '{OP_INC,    3'd0, 4'd1, 1'b1, 1'b1, 1, 0};
        vec[16] = '{OP_RESET,  3'd0, 4'd0, 1'b1, 1'b1, 0, 1};
        vec[17] = '{OP_SW_OFF, 3'd5, 4'd0, 1'b1, 1'b0, 0, 0};
        vec[18] = '{OP_PAUSE,  3'd5, 4'd0, 1'b0, 1'b0, 0, 0};
        vec[19] = '{OP_SEL,    3'd5, 4'd0, 1'b0, 1'b0, 0, 0};
        vec[20] = '{OP_INC,    3'd5, 4'd0, 1'b0, 1'b0, 0, 0};
        vec[21] = '{OP_RESET,  3'd5, 4'd0, 1'b0, 1'b0, 0, 1};

        raw   = '0;
        rst_n = 1'b0;
        #1;
        chk_reset_values("reset");
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Bounce: three toggles in three cycles, final edge to 1
        raw[0] = 1'b1; tick(1);
        raw[0] = 1'b0; tick(1);
        raw[0] = 1'b1;
        tick(6);
        chk("bounce_paused_at_6", paused, 0);
        tick(1);
        chk("bounce_paused_at_7", paused, 1);
        tick(10);
        chk("bounce_single_toggle", paused, 1);
        raw[0] = 1'b0;
        tick(10);

        // Reset press while running
        r0 = n_rst;
        hi_cycles = 0;
        raw[1] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (rst_cnt) hi_cycles++;
            if (i == 7) raw[1] = 1'b0;
        end
        chk("run_rst_cnt_cycles", hi_cycles, 1);
        chk("run_rst_pulses", n_rst - r0, 1);
        chk("run_rst_paused_kept", paused, 1);

        for (int i = 0; i < NV; i++) begin
            s0 = n_strobe;
            r0 = n_rst;
            do_op(vec[i].op);
            chk($sformatf("vec%0d_paused", i), paused, vec[i].paused);
            chk($sformatf("vec%0d_adj", i), adj, vec[i].adj);
            chk($sformatf("vec%0d_adj_sel", i), adj_sel, vec[i].sel);
            if (vec[i].adj) chk($sformatf("vec%0d_adj_val", i), adj_val, vec[i].val);
            chk($sformatf("vec%0d_strobes", i), n_strobe - s0, vec[i].strobes);
            if (vec[i].strobes > 0) begin
                chk($sformatf("vec%0d_strobe_sel", i), last_sel, vec[i].sel);
                chk($sformatf("vec%0d_strobe_val", i), last_val, vec[i].val);
            end
            chk($sformatf("vec%0d_rst_pulses", i), n_rst - r0, vec[i].rsts);
        end

        // Simultaneous select and increment
        do_op(OP_SW_ON);
        do_op(OP_INC);
        do_op(OP_INC);
        chk("sim_pre_val", adj_val, 2);
        s0 = n_strobe;
        raw[2] = 1'b1;
        raw[3] = 1'b1;
        tick(8);
        raw[2] = 1'b0;
        raw[3] = 1'b0;
        tick(8);
        chk("sim_adj_sel", adj_sel, 1);
        chk("sim_adj_val", adj_val, 0);
        chk("sim_no_strobe", n_strobe - s0, 0);

        // Asynchronous reset in the middle of adjust mode
        do_op(OP_INC);
        rst_n = 1'b0;
        #1;
        chk_reset_values("midreset");
        tick(1);
        rst_n = 1'b1;
        tick(12);
        chk("midreset_adj", adj, 1);
        chk("midreset_adj_sel", adj_sel, 0);
        chk("midreset_adj_val", adj_val, 0);
        chk("midreset_paused", paused, 1);

        // Randomized operations against the reference model
        m_paused_q = 1'b0;
        m_adj      = 1'b1;
        m_ptr      = 0;
        m_val      = 0;
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 5));
            s0 = n_strobe;
            r0 = n_rst;
            do_op(op);
            model_op(op);
            chk($sformatf("rnd%0d_paused", i), paused, m_adj ? 1 : int'(m_paused_q));
            chk($sformatf("rnd%0d_adj", i), adj, m_adj);
            chk($sformatf("rnd%0d_adj_sel", i), adj_sel, m_adj ? m_ptr : 5);
            if (m_adj) chk($sformatf("rnd%0d_adj_val", i), adj_val, m_val);
            chk($sformatf("rnd%0d_strobes", i), n_strobe - s0, (op == OP_INC && m_adj) ? 1 : 0);
            if (op == OP_INC && m_adj) chk($sformatf("rnd%0d_strobe_val", i), last_val, m_val);
            chk($sformatf("rnd%0d_rst_pulses", i), n_rst - r0, (op == OP_RESET) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
